// File: rtl/opb_reg_bank_pkg.sv
// Shared constants and helpers for the OPB register bank.
// Bit positions are numeric (bit 0 = LSB = OPB bit 31).
package opb_reg_bank_pkg;

    localparam int CTRL_PENDING_BIT = 0;
    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_NREGS_LSB   = 8;
    localparam int CTRL_NREGS_MSB   = 15;

    localparam logic [31:0] RST_WORD = 32'h0000_0000;
    localparam logic        RST_BIT  = 1'b0;

    // Wide enough to name every data register plus the control register.
    function automatic int idxWidth(input int numRegs);
        return (numRegs < 1) ? 1 : $clog2(numRegs + 1);
    endfunction

    function automatic logic [31:0] byteMerge(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  byteEn);
        logic [31:0] merged;
        merged = oldWord;
        for (int j = 0; j < 4; j++) begin
            if (byteEn[j]) merged[8*j +: 8] = newWord[8*j +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/opb_reg_bank_slave_if.sv
// OPB slave front end: address decode, word index and the two-cycle ack.
module opb_reg_bank_slave_if
    import opb_reg_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_0700,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_07FF,
    parameter int          C_NUM_REGS = 8
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [31:0]                         addr_i,
    input  logic                                select_i,
    output logic                                start_o,
    output logic                                ack_o,
    output logic                                isData_o,
    output logic                                isCtrl_o,
    output logic [idxWidth(C_NUM_REGS)-1:0]     regIdx_o
);

    logic        hit;
    logic [31:0] offset;
    logic [31:0] wordIdx;
    logic        ack_q;
    logic        ack_d;
    logic        unusedOffsetBits;

    assign hit     = select_i && (addr_i >= C_BASEADDR) && (addr_i <= C_HIGHADDR);
    assign offset  = addr_i - C_BASEADDR;
    assign wordIdx = {2'b00, offset[31:2]};

    // A transfer starts on any hit cycle not already acknowledging, so a held
    // select re-arms every second cycle.
    assign start_o = hit && !ack_q;
    assign ack_d   = start_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_q <= RST_BIT;
        end else begin
            ack_q <= ack_d;
        end
    end

    assign ack_o            = ack_q;
    assign isData_o         = wordIdx < 32'(C_NUM_REGS);
    assign isCtrl_o         = wordIdx == 32'(C_NUM_REGS);
    assign regIdx_o         = wordIdx[idxWidth(C_NUM_REGS)-1:0];
    assign unusedOffsetBits = ^offset[1:0];

endmodule

// File: rtl/opb_reg_bank_ppc2simulink.sv
// OPB register bank exporting user registers, optionally double-buffered
// behind a commit bit so consumers never see a partial multi-register update.
module opb_reg_bank_ppc2simulink
    import opb_reg_bank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_07FF,
    parameter int          C_NUM_REGS   = 8,
    parameter int          C_SHADOW     = 1,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]    user_data_out,
    output logic [C_NUM_REGS-1:0]       user_wr_strobe
);

    localparam int IDXW = idxWidth(C_NUM_REGS);

    logic [31:0]           addrLe;
    logic [31:0]           wrData;
    logic [3:0]            byteEn;
    logic                  start;
    logic                  ack;
    logic                  isData;
    logic                  isCtrl;
    logic [IDXW-1:0]       regIdx;
    logic                  commit;
    logic [31:0]           readWord;
    logic                  unusedInputs;

    logic [31:0]           shadow_q [C_NUM_REGS];
    logic [31:0]           shadow_d [C_NUM_REGS];
    logic [31:0]           active_q [C_NUM_REGS];
    logic [31:0]           active_d [C_NUM_REGS];
    logic                  pending_q, pending_d;
    logic [C_NUM_REGS-1:0] strobe_q, strobe_d;
    logic [31:0]           rdData_q, rdData_d;

    // Big-endian OPB vectors copy MSB-to-MSB, so numeric values carry over.
    assign addrLe       = OPB_ABus;
    assign wrData       = OPB_DBus;
    assign byteEn       = OPB_BE;
    assign unusedInputs = OPB_seqAddr;

    opb_reg_bank_slave_if #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .C_NUM_REGS (C_NUM_REGS)
    ) u_slave_if (
        .clk_i    (OPB_Clk),
        .rst_n_i  (OPB_Rst_n),
        .addr_i   (addrLe),
        .select_i (OPB_select),
        .start_o  (start),
        .ack_o    (ack),
        .isData_o (isData),
        .isCtrl_o (isCtrl),
        .regIdx_o (regIdx)
    );

    assign commit = isCtrl && byteEn[CTRL_COMMIT_BIT] && wrData[CTRL_COMMIT_BIT];

    always_comb begin
        readWord = RST_WORD;
        if (isData) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (regIdx == IDXW'(i)) readWord = (C_SHADOW != 0) ? shadow_q[i] : active_q[i];
            end
        end else if (isCtrl) begin
            readWord[CTRL_NREGS_MSB:CTRL_NREGS_LSB] = 8'(C_NUM_REGS);
            readWord[CTRL_PENDING_BIT]              = pending_q;
        end
    end

    // Register updates land on the edge that raises the ack, so they are
    // visible during the ack cycle together with the strobes.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        strobe_d  = '0;
        rdData_d  = RST_WORD;
        if (start) begin
            if (OPB_RNW) begin
                rdData_d = readWord;
            end else if (isData) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (regIdx == IDXW'(i)) begin
                        if (C_SHADOW != 0) begin
                            shadow_d[i] = byteMerge(shadow_q[i], wrData, byteEn);
                            pending_d   = 1'b1;
                        end else begin
                            active_d[i] = byteMerge(active_q[i], wrData, byteEn);
                            strobe_d[i] = 1'b1;
                        end
                    end
                end
            end else if (commit && (C_SHADOW != 0)) begin
                active_d  = shadow_q;
                strobe_d  = '1;
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                shadow_q[i] <= RST_WORD;
                active_q[i] <= RST_WORD;
            end
            pending_q <= RST_BIT;
            strobe_q  <= '0;
            rdData_q  <= RST_WORD;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            strobe_q  <= strobe_d;
            rdData_q  <= rdData_d;
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : gen_user_out
        assign user_data_out[32*g +: 32] = active_q[g];
    end

    assign Sl_DBus        = rdData_q;
    assign Sl_xferAck     = ack;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_wr_strobe = strobe_q;

endmodule

// File: doc/opb_reg_bank_ppc2simulink.md
OPB_REG_BANK_PPC2SIMULINK -- requirements
Module: opb_reg_bank_ppc2simulink

Interface
REQ-001 SHALL have parameter C_BASEADDR, default 32'h01000700, first byte address of the bank.
REQ-002 SHALL have parameter C_HIGHADDR, default 32'h010007FF, last byte address of the bank.
REQ-003 SHALL have parameter C_NUM_REGS, default 8, number of user registers (1..64).
REQ-004 SHALL have parameter C_SHADOW, default 1: 1 = double-buffered with commit, 0 = direct update.
REQ-005 SHALL have parameters C_OPB_AWIDTH and C_OPB_DWIDTH, both default 32, fixed bus widths.
REQ-006 SHALL have port OPB_Clk, input, 1: the only clock; all logic on its rising edge.
REQ-007 SHALL have port OPB_Rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have ports OPB_ABus [0:31], OPB_BE [0:3], OPB_DBus [0:31], OPB_RNW, OPB_select and OPB_seqAddr as inputs, with standard OPB slave meaning.
REQ-009 SHALL have ports Sl_DBus [0:31], Sl_xferAck, Sl_errAck, Sl_retry and Sl_toutSup as outputs.
REQ-010 SHALL have port user_data_out, output, C_NUM_REGS*32: register i on bits [32i+31:32i], OPB bit 0 mapping to bit 31.
REQ-011 SHALL have port user_wr_strobe, output, C_NUM_REGS: 1-cycle pulse when active register i is loaded.

Function
REQ-012 SHALL treat an access as a hit when OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; word index = (OPB_ABus - C_BASEADDR) >> 2.
REQ-013 SHALL map index 0..C_NUM_REGS-1 to data registers and index C_NUM_REGS to the control register.
REQ-014 SHALL make higher indices read 0, ignore writes to them, and still acknowledge them.
REQ-015 SHALL handshake so that on a hit with no ack in the current cycle, Sl_xferAck=1 for exactly one cycle, in the following cycle; each transfer therefore takes 2 cycles, and select held after ack starts a new transfer.
REQ-016 SHALL drive Sl_DBus with read data only while Sl_xferAck=1, and 0 otherwise.
REQ-017 SHALL tie Sl_errAck, Sl_retry and Sl_toutSup to 0 and ignore OPB_seqAddr.
REQ-018 SHALL perform writes in the ack cycle: OPB_BE[k] enables OPB_DBus[8k:8k+7]; unselected bytes are unchanged.
REQ-019 SHALL, when C_SHADOW=1, write data registers to the shadow copy, set pending=1, and leave active registers and strobes unchanged.
REQ-020 SHALL, when C_SHADOW=1 and a control write has BE[3]=1 with OPB_DBus[31]=1 (commit), copy all shadows to active, pulse all user_wr_strobe bits and clear pending, all in that ack cycle.
REQ-021 SHALL treat a commit with pending=0 as still copying and pulsing.
REQ-022 SHALL, when C_SHADOW=0, update active register i directly and pulse only user_wr_strobe[i]; a commit is a no-op.
REQ-023 SHALL read data registers as the shadow value (C_SHADOW=1) or active value (C_SHADOW=0).
REQ-024 SHALL read the control register as bit 31 (LSB) = pending, bits [16:23] = C_NUM_REGS, and all other bits 0.
REQ-025 SHALL drive user_data_out from active registers only, so it never shows a partial multi-register update.

Reset
REQ-026 SHALL, when OPB_Rst_n=0, asynchronously clear all shadow and active registers, pending, Sl_xferAck, Sl_DBus and user_wr_strobe to 0.
REQ-027 SHALL, if reset is asserted mid-transfer, abort the transfer with no ack; after release, a still-asserted select starts a fresh transfer.

Structure
REQ-028 SHALL place the control-register bit positions, the index-decode width function and the reset constants in package opb_reg_bank_pkg.
REQ-029 SHALL implement address hit, index and ack generation in one sub-module, opb_reg_bank_slave_if; storage stays in the top level.

Verification
REQ-030 SHALL cover reset values: after reset, user_data_out=0, strobe=0, and a control read returns 0x00000800 for 8 registers.
REQ-031 SHALL cover shadow commit: write 0xDEADBEEF to idx 2 -> user_data_out unchanged and a control read gives pending=1; commit write 0x00000001 -> reg 2 = 0xDEADBEEF, strobe=0xFF for 1 cycle, pending=0.
REQ-032 SHALL cover byte enables: with idx 0 holding 0x11223344, write 0xAABBCCDD with BE=0101 -> readback 0x11BB33DD.
REQ-033 SHALL cover direct mode: with C_SHADOW=0, write 0x5 to idx 7 -> user_data_out[255:224]=0x5 and strobe=0x80, both in the ack cycle.
REQ-034 SHALL cover out-of-range access: read idx 20 -> ack 1 cycle after select with Sl_DBus=0; outside C_BASEADDR..C_HIGHADDR -> no ack and Sl_DBus=0.
REQ-035 SHALL cover reset mid-transfer: assert OPB_Rst_n=0 in the cycle after select -> no ack, no register change.
